fetch_queue: RTL and testbench

Instruction fetch queue sitting between the instruction memory and the decode pipeline register. It owns the fetch PC, issues one-at-a-time requests to a variable-latency instruction memory, and buffers returned instructions with their PC+4. Decode pops entries under the existing decode stall. A taken branch from execute redirects fetch, flushes the queue, and discards any in-flight response.

---
 rtl/fetch_queue_if.sv | 52 +++++
 rtl/fetch_queue.sv | 155 +++++++++++++++
 tb/tb_fetch_queue.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundle of the fetch queue's memory-side, control and
// decode-side signals.
//   master : fetch_queue side (drives imem_req/imem_addr and the decode outputs)
//   slave  : environment side (instruction memory, execute, decode)
// Signals:
//   imem_req/imem_addr      fetch request and address
//   imem_ack/imem_rdata     memory response
//   redirect/redirect_pc    taken branch and its target
//   stall                   decode stall, head not consumed while high
//   instr_valid/instr_out/pcplus4_out/occupancy  head entry and fill level
// Optional feature macro FETCHQ_PERF_EN adds empty_cycles and redirect_count.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic          instr_valid;
  logic [31:0]   instr_out;
  logic [31:0]   pcplus4_out;
  logic [CW-1:0] occupancy;
`ifdef FETCHQ_PERF_EN
  logic [31:0]   empty_cycles;
  logic [31:0]   redirect_count;
`endif

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc, stall,
    output instr_valid, instr_out, pcplus4_out, occupancy
`ifdef FETCHQ_PERF_EN
    , output empty_cycles, redirect_count
`endif
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc, stall,
    input  instr_valid, instr_out, pcplus4_out, occupancy
`ifdef FETCHQ_PERF_EN
    , input empty_cycles, redirect_count
`endif
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between instruction memory and decode.
// Owns the fetch PC, issues one outstanding request at a time to a
// variable-latency memory and buffers {instr, pc+4} entries for decode.
// A redirect flushes the queue and discards any in-flight response.
// Ports:
//   clk    rising-edge pipeline clock
//   reset  asynchronous active-high reset, clears all state
//   fq     fetch_queue_if.master (memory, redirect, stall, decode outputs)
// Optional feature macro FETCHQ_PERF_EN: empty_cycles / redirect_count counters.
//
// state | meaning
// IDLE  | no request; waiting for room in the queue
// REQ   | request to req_addr outstanding; response is kept
// DROP  | request outstanding after a redirect; response is discarded
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master fq
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
  state_t state, state_nxt;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc4_mem   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_addr, req_addr_nxt;
  logic          valid, push, pop, flush;

  assign valid = (count != '0);
  assign flush = fq.redirect;
  assign pop   = valid && !fq.stall;
  // A response that coincides with a redirect belongs to the wrong path.
  assign push  = (state == REQ) && fq.imem_ack && !fq.redirect;

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (fq.redirect)
      fetch_pc_nxt = fq.redirect_pc;
    else if (push)
      fetch_pc_nxt = fetch_pc + 32'd4;
  end

  // Every entry into REQ latches the post-edge fetch PC as the new address,
  // so imem_addr only moves when a request completes or starts.
  always_comb begin
    state_nxt    = state;
    req_addr_nxt = req_addr;
    case (state)
      IDLE: begin
        if (count_nxt < FULL) begin
          state_nxt    = REQ;
          req_addr_nxt = fetch_pc_nxt;
        end
      end
      REQ: begin
        if (fq.redirect) begin
          if (fq.imem_ack) begin
            state_nxt    = REQ;
            req_addr_nxt = fetch_pc_nxt;
          end else begin
            state_nxt = DROP;
          end
        end else if (fq.imem_ack) begin
          if (count_nxt < FULL) begin
            state_nxt    = REQ;
            req_addr_nxt = fetch_pc_nxt;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (fq.imem_ack) begin
          state_nxt    = REQ;
          req_addr_nxt = fetch_pc_nxt;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      count    <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= fq.imem_rdata;
      pc4_mem[wr_ptr]   <= req_addr + 32'd4;
    end
  end

  assign fq.imem_req    = (state != IDLE);
  assign fq.imem_addr   = req_addr;
  assign fq.instr_valid = valid;
  assign fq.instr_out   = valid ? instr_mem[rd_ptr] : 32'h0000_0000;
  assign fq.pcplus4_out = valid ? pc4_mem[rd_ptr] : 32'h0000_0000;
  assign fq.occupancy   = count;

`ifdef FETCHQ_PERF_EN
  logic [31:0] empty_cycles, redirect_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      empty_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!valid && !fq.stall) empty_cycles <= empty_cycles + 32'd1;
      if (fq.redirect)         redirect_count <= redirect_count + 32'd1;
    end
  end

  assign fq.empty_cycles   = empty_cycles;
  assign fq.redirect_count = redirect_count;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue (default build).
// A behavioural instruction memory answers requests after mem_lat wait
// cycles with an address-derived word; expected decode entries are queued
// by each scenario and popped as decode consumes the head.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } entry_t;

  logic   clk;
  logic   reset;
  int     mem_lat;
  int     n_checks;
  int     n_fail;
  entry_t exp_q[$];
  entry_t e;

  fetch_queue_if #(.DEPTH(DEPTH)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .fq   (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  // Instruction memory model: ack after mem_lat waiting cycles of a request.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    fq.imem_ack   = 1'b0;
    fq.imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (fq.imem_req === 1'b1) begin
        if (wait_cnt >= mem_lat) begin
          fq.imem_ack   = 1'b1;
          fq.imem_rdata = word_of(fq.imem_addr);
          wait_cnt      = 0;
        end else begin
          fq.imem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        fq.imem_ack = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  // Leaves the bench at the negedge on which reset was released.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    fq.redirect = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.instr_valid, fq.instr_out, fq.pcplus4_out, fq.occupancy}
        !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, CW'(0)}) begin
      n_fail++;
      $display("FAIL reset_values: req=%b addr=%h valid=%b instr=%h pc4=%h occ=%0d, want all zero",
               fq.imem_req, fq.imem_addr, fq.instr_valid, fq.instr_out, fq.pcplus4_out, fq.occupancy);
    end
  endtask

  task automatic test_zero_wait();
    fq.stall = 1'b0;
    mem_lat  = 0;
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back({word_of(32'(4 * i)), 32'(4 * i + 4)});
    @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.instr_valid} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h valid=%b, want 1 00000000 0",
               fq.imem_req, fq.imem_addr, fq.instr_valid);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fq.instr_valid, fq.imem_req, fq.imem_addr} !== {1'b1, 1'b1, 32'(4 * (i + 1))}) begin
        n_fail++;
        $display("FAIL zw_stream[%0d]: valid=%b req=%b addr=%h, want 1 1 %h",
                 i, fq.instr_valid, fq.imem_req, fq.imem_addr, 32'(4 * (i + 1)));
      end
      if (fq.instr_valid && !fq.stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL zw_pop: extra entry instr=%h, want none", fq.instr_out);
        end else begin
          e = exp_q.pop_front();
          if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
            n_fail++;
            $display("FAIL zw_pop: instr=%h pc4=%h, want %h %h",
                     fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
          end
        end
      end
    end
  endtask

  task automatic test_stall_full();
    int k;
    fq.stall = 1'b1;
    mem_lat  = 0;
    exp_q.delete();
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back({word_of(32'(4 * i)), 32'(4 * i + 4)});
    k = 0;
    while (fq.occupancy !== CW'(DEPTH) && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 20) begin
      n_fail++;
      $display("FAIL full_timeout: occ=%0d, want %0d", fq.occupancy, DEPTH);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({fq.imem_req, fq.occupancy} !== {1'b0, CW'(DEPTH)}) begin
        n_fail++;
        $display("FAIL full_hold[%0d]: req=%b occ=%0d, want 0 %0d",
                 i, fq.imem_req, fq.occupancy, DEPTH);
      end
      @(negedge clk);
    end
    fq.stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        n_checks++;
        if ({fq.imem_req, fq.imem_addr} !== {1'b1, 32'h10}) begin
          n_fail++;
          $display("FAIL resume_addr: req=%b addr=%h, want 1 00000010", fq.imem_req, fq.imem_addr);
        end
      end
      if (fq.instr_valid && !fq.stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL drain_pop: extra entry instr=%h, want none", fq.instr_out);
        end else begin
          e = exp_q.pop_front();
          if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
            n_fail++;
            $display("FAIL drain_pop: instr=%h pc4=%h, want %h %h",
                     fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
          end
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_slow_mem();
    fq.stall = 1'b1;
    mem_lat  = 3;
    exp_q.delete();
    do_reset();
    exp_q.push_back({word_of(32'h0), 32'h4});
    exp_q.push_back({word_of(32'h4), 32'h8});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({fq.imem_req, fq.imem_addr, fq.occupancy} !== {1'b1, 32'(4 * (i / 4)), CW'(i / 4)}) begin
        n_fail++;
        $display("FAIL slow_cycle[%0d]: req=%b addr=%h occ=%0d, want 1 %h %0d",
                 i, fq.imem_req, fq.imem_addr, fq.occupancy, 32'(4 * (i / 4)), i / 4);
      end
    end
    fq.stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (!(fq.instr_valid && exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL slow_pop: valid=%b queued=%0d, want 1 and nonzero", fq.instr_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
          n_fail++;
          $display("FAIL slow_pop: instr=%h pc4=%h, want %h %h",
                   fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
        end
      end
      @(negedge clk);
    end
    fq.stall = 1'b1;
  endtask

  task automatic test_redirect_waiting();
    int k;
    fq.stall = 1'b1;
    mem_lat  = 3;
    exp_q.delete();
    do_reset();
    repeat (9) @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.occupancy} !== {1'b1, 32'h8, CW'(2)}) begin
      n_fail++;
      $display("FAIL rdw_setup: req=%b addr=%h occ=%0d, want 1 00000008 2",
               fq.imem_req, fq.imem_addr, fq.occupancy);
    end
    @(negedge clk);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h100;
    exp_q.delete();
    exp_q.push_back({word_of(32'h100), 32'h104});
    @(negedge clk);
    fq.redirect = 1'b0;
    n_checks++;
    if ({fq.occupancy, fq.instr_valid, fq.instr_out, fq.imem_req, fq.imem_addr}
        !== {CW'(0), 1'b0, 32'h0, 1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL rdw_flush: occ=%0d valid=%b instr=%h req=%b addr=%h, want 0 0 0 1 00000008",
               fq.occupancy, fq.instr_valid, fq.instr_out, fq.imem_req, fq.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL rdw_hold: req=%b addr=%h, want 1 00000008", fq.imem_req, fq.imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.occupancy} !== {1'b1, 32'h100, CW'(0)}) begin
      n_fail++;
      $display("FAIL rdw_target: req=%b addr=%h occ=%0d, want 1 00000100 0",
               fq.imem_req, fq.imem_addr, fq.occupancy);
    end
    k = 0;
    while (fq.instr_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    fq.stall = 1'b0;
    n_checks++;
    if (k >= 20 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL rdw_arrival: valid=%b after %0d cycles, want 1", fq.instr_valid, k);
    end else begin
      e = exp_q.pop_front();
      if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
        n_fail++;
        $display("FAIL rdw_pop: instr=%h pc4=%h, want %h %h",
                 fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
      end
    end
    @(negedge clk);
    fq.stall = 1'b1;
  endtask

  task automatic test_redirect_ack_pop();
    fq.stall = 1'b1;
    mem_lat  = 0;
    exp_q.delete();
    do_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({fq.occupancy, fq.imem_req, fq.imem_addr} !== {CW'(2), 1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL rap_setup: occ=%0d req=%b addr=%h, want 2 1 00000008",
               fq.occupancy, fq.imem_req, fq.imem_addr);
    end
    fq.stall       = 1'b0;
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'h40;
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back({word_of(32'(32'h40 + 4 * i)), 32'(32'h44 + 4 * i)});
    @(negedge clk);
    fq.redirect = 1'b0;
    n_checks++;
    if ({fq.occupancy, fq.instr_valid, fq.instr_out, fq.imem_req, fq.imem_addr}
        !== {CW'(0), 1'b0, 32'h0, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL rap_flush: occ=%0d valid=%b instr=%h req=%b addr=%h, want 0 0 0 1 00000040",
               fq.occupancy, fq.instr_valid, fq.instr_out, fq.imem_req, fq.imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (!(fq.instr_valid && exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL rap_pop[%0d]: valid=%b queued=%0d, want 1 and nonzero", i, fq.instr_valid, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
          n_fail++;
          $display("FAIL rap_pop[%0d]: instr=%h pc4=%h, want %h %h",
                   i, fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
        end
      end
    end
    fq.stall = 1'b1;
  endtask

  task automatic test_pc_wrap();
    fq.stall = 1'b1;
    mem_lat  = 0;
    exp_q.delete();
    do_reset();
    @(negedge clk);
    fq.redirect    = 1'b1;
    fq.redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back({word_of(32'hFFFF_FFFC), 32'h0});
    @(negedge clk);
    fq.redirect = 1'b0;
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.occupancy} !== {1'b1, 32'hFFFF_FFFC, CW'(0)}) begin
      n_fail++;
      $display("FAIL wrap_req: req=%b addr=%h occ=%0d, want 1 fffffffc 0",
               fq.imem_req, fq.imem_addr, fq.occupancy);
    end
    @(negedge clk);
    n_checks++;
    if ({fq.imem_addr, fq.occupancy} !== {32'h0, CW'(1)}) begin
      n_fail++;
      $display("FAIL wrap_next: addr=%h occ=%0d, want 00000000 1", fq.imem_addr, fq.occupancy);
    end
    fq.stall = 1'b0;
    n_checks++;
    if (!(fq.instr_valid && exp_q.size() != 0)) begin
      n_fail++;
      $display("FAIL wrap_pop: valid=%b, want 1", fq.instr_valid);
    end else begin
      e = exp_q.pop_front();
      if ({fq.instr_out, fq.pcplus4_out} !== {e.instr, e.pc4}) begin
        n_fail++;
        $display("FAIL wrap_pop: instr=%h pc4=%h, want %h %h",
                 fq.instr_out, fq.pcplus4_out, e.instr, e.pc4);
      end
    end
    @(negedge clk);
    fq.stall = 1'b1;
  endtask

  task automatic test_reset_midreq();
    fq.stall = 1'b1;
    mem_lat  = 0;
    exp_q.delete();
    do_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if ({fq.occupancy, fq.imem_req} !== {CW'(3), 1'b1}) begin
      n_fail++;
      $display("FAIL mid_setup: occ=%0d req=%b, want 3 1", fq.occupancy, fq.imem_req);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.instr_valid, fq.instr_out, fq.pcplus4_out, fq.occupancy}
        !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, CW'(0)}) begin
      n_fail++;
      $display("FAIL mid_reset: req=%b addr=%h valid=%b instr=%h pc4=%h occ=%0d, want all zero",
               fq.imem_req, fq.imem_addr, fq.instr_valid, fq.instr_out, fq.pcplus4_out, fq.occupancy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({fq.imem_req, fq.imem_addr, fq.occupancy} !== {1'b1, 32'h0, CW'(0)}) begin
      n_fail++;
      $display("FAIL mid_restart: req=%b addr=%h occ=%0d, want 1 00000000 0",
               fq.imem_req, fq.imem_addr, fq.occupancy);
    end
    @(negedge clk);
    n_checks++;
    if ({fq.occupancy, fq.instr_out, fq.pcplus4_out} !== {CW'(1), word_of(32'h0), 32'h4}) begin
      n_fail++;
      $display("FAIL mid_first: occ=%0d instr=%h pc4=%h, want 1 %h 00000004",
               fq.occupancy, fq.instr_out, fq.pcplus4_out, word_of(32'h0));
    end
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    mem_lat        = 0;
    reset          = 1'b1;
    fq.stall       = 1'b0;
    fq.redirect    = 1'b0;
    fq.redirect_pc = 32'h0;
    test_reset();
    test_zero_wait();
    test_stall_full();
    test_slow_mem();
    test_redirect_waiting();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_midreq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
